// File: rtl/img_crop_dma_if.sv
// Control and memory-port bundle of the crop/decimate engine.
// master = the engine itself, slave = the controller plus memories around it.
interface img_crop_dma_if #(
  parameter int SRC_AW = 15,
  parameter int DST_AW = 10,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ROW_W-1:0]  crop_row;
  logic [COL_W-1:0]  crop_col;
  logic [1:0]        step;
  logic              busy;
  logic              done;
  logic              err;
  logic              ce_src;
  logic [SRC_AW-1:0] addr_src;
  logic [DATA_W-1:0] rd_data;
  logic              ce_dst;
  logic [DST_AW-1:0] addr_dst;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  start, crop_row, crop_col, step, rd_data,
    output busy, done, err, ce_src, addr_src, ce_dst, addr_dst, wr_data
  );

  modport slave (
    output start, crop_row, crop_col, step, rd_data,
    input  busy, done, err, ce_src, addr_src, ce_dst, addr_dst, wr_data
  );
endinterface

// File: rtl/img_crop_dma.sv
// Copies a strided DST_W x DST_H window out of a SRC_W x SRC_H image, one pixel per cycle.
// Reads stream in raster order; each read is written to the destination on the following cycle.
module img_crop_dma #(
  parameter int SRC_W  = 256,
  parameter int SRC_H  = 128,
  parameter int SRC_AW = 15,
  parameter int DST_W  = 32,
  parameter int DST_H  = 32,
  parameter int DST_AW = 10,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  img_crop_dma_if.master bus
);
  localparam int N  = DST_W * DST_H;
  localparam int CW = $clog2(DST_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_step;
  logic              r_err;
  logic              r_ce_dst;
  logic [SRC_AW-1:0] r_addr_src;
  logic [SRC_AW-1:0] r_row_base;
  logic [DST_AW-1:0] r_addr_dst;
  logic [DST_AW-1:0] r_pix;
  logic [CW-1:0]     r_col;

  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [DATA_W-1:0] w_pix;
  logic [31:0]       w_row_last;
  logic [31:0]       w_col_last;
  logic              w_fit;
  logic              w_accept;
  logic              w_last;
  logic [SRC_AW-1:0] w_origin;
  logic [SRC_AW-1:0] w_col_inc;
  logic [SRC_AW-1:0] w_row_inc;

  assign w_row    = bus.crop_row;
  assign w_col    = bus.crop_col;
  assign w_pix    = bus.rd_data;

  // Last row/column touched, computed 32 bits wide so large origins cannot wrap into range.
  assign w_row_last = 32'(w_row) + (32'(DST_H - 1) << bus.step);
  assign w_col_last = 32'(w_col) + (32'(DST_W - 1) << bus.step);
  assign w_fit      = (w_row_last <= 32'(SRC_H - 1)) && (w_col_last <= 32'(SRC_W - 1));
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_last     = (r_pix == DST_AW'(N - 1));

  // The only multiply happens once per accepted start; per-pixel stepping is add-only.
  assign w_origin  = SRC_AW'(32'(w_row) * 32'(SRC_W) + 32'(w_col));
  assign w_col_inc = SRC_AW'(1) << r_step;
  assign w_row_inc = SRC_AW'(SRC_W) << r_step;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = w_fit ? S_READ : S_DONE;
      S_READ:  if (w_last) w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ce_src = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (r_state)
      S_READ:  begin bus.ce_src = 1'b1; bus.busy = 1'b1; end
      S_FLUSH: bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step     <= '0;
      r_err      <= 1'b0;
      r_ce_dst   <= 1'b0;
      r_addr_src <= '0;
      r_row_base <= '0;
      r_addr_dst <= '0;
      r_pix      <= '0;
      r_col      <= '0;
    end else begin
      r_ce_dst <= (r_state == S_READ);
      if (w_accept) begin
        r_step     <= bus.step;
        r_err      <= !w_fit;
        r_addr_src <= w_origin;
        r_row_base <= w_origin;
        r_pix      <= '0;
        r_col      <= '0;
      end else if (r_state == S_READ) begin
        r_addr_dst <= r_pix;
        r_pix      <= r_pix + DST_AW'(1);
        if (r_col == CW'(DST_W - 1)) begin
          r_col      <= '0;
          r_row_base <= r_row_base + w_row_inc;
          r_addr_src <= r_row_base + w_row_inc;
        end else begin
          r_col      <= r_col + CW'(1);
          r_addr_src <= r_addr_src + w_col_inc;
        end
      end
    end
  end

  assign bus.err      = r_err;
  assign bus.addr_src = r_addr_src;
  assign bus.ce_dst   = r_ce_dst;
  assign bus.addr_dst = r_addr_dst;
  assign bus.wr_data  = w_pix;
endmodule

// File: tb/tb_img_crop_dma.sv
// Drives two engines (default 256x128 image and a 100x60 image) with directed and random
// windows; expected reads, writes and timing come from plain window arithmetic.
module tb_img_crop_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  img_crop_dma_if #(.SRC_AW(15), .DST_AW(10), .ROW_W(7), .COL_W(8), .DATA_W(8)) ifa ();
  img_crop_dma_if #(.SRC_AW(13), .DST_AW(6),  .ROW_W(6), .COL_W(7), .DATA_W(8)) ifb ();

  img_crop_dma #(
    .SRC_W(256), .SRC_H(128), .SRC_AW(15), .DST_W(32), .DST_H(32),
    .DST_AW(10), .ROW_W(7), .COL_W(8), .DATA_W(8)
  ) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.master));

  img_crop_dma #(
    .SRC_W(100), .SRC_H(60), .SRC_AW(13), .DST_W(8), .DST_H(8),
    .DST_AW(6), .ROW_W(6), .COL_W(7), .DATA_W(8)
  ) u_dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  function automatic logic [7:0] src_val(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[14:8];
  endfunction

  // Single-port source memories with one cycle of read latency.
  always @(posedge clk) begin
    if (ifa.ce_src) ifa.rd_data <= src_val(int'(ifa.addr_src));
    if (ifb.ce_src) ifb.rd_data <= src_val(int'(ifb.addr_src));
  end

  int sel = 0;
  int sw, sh, dw, dh;
  logic m_busy, m_done, m_err, m_ce_src, m_ce_dst;
  logic [31:0] m_asrc, m_adst;
  logic [7:0]  m_wd;

  always_comb begin
    if (sel == 0) begin
      m_busy = ifa.busy; m_done = ifa.done; m_err = ifa.err;
      m_ce_src = ifa.ce_src; m_ce_dst = ifa.ce_dst;
      m_asrc = 32'(ifa.addr_src); m_adst = 32'(ifa.addr_dst); m_wd = ifa.wr_data;
    end else begin
      m_busy = ifb.busy; m_done = ifb.done; m_err = ifb.err;
      m_ce_src = ifb.ce_src; m_ce_dst = ifb.ce_dst;
      m_asrc = 32'(ifb.addr_src); m_adst = 32'(ifb.addr_dst); m_wd = ifb.wr_data;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_sel(input int s);
    sel = s;
    if (s == 0) begin sw = 256; sh = 128; dw = 32; dh = 32; end
    else        begin sw = 100; sh = 60;  dw = 8;  dh = 8;  end
  endtask

  task automatic drive(input logic s, input int r, input int c, input int st);
    if (sel == 0) begin
      ifa.start = s; ifa.crop_row = 7'(r); ifa.crop_col = 8'(c); ifa.step = 2'(st);
    end else begin
      ifb.start = s; ifb.crop_row = 6'(r); ifb.crop_col = 7'(c); ifb.step = 2'(st);
    end
  endtask

  int rd_q[$];
  int wa_q[$];
  int wd_q[$];
  int n_busy, busy_first, busy_last, n_done, cyc_done, n_after;
  logic err_done, err0;

  // Cycle 0 is the start cycle; outputs of cycle k are sampled at its falling edge.
  task automatic run(input string tag, input int r0, input int c0, input int st,
                     input int hold, input int pulse_at, input int rst_at, input int budget);
    int s, n, bad_rd, bad_wa, bad_wd, a, i, j;
    logic fit;
    logic idle0;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    n_busy = 0; busy_first = -1; busy_last = -1; n_done = 0; cyc_done = -1; n_after = 0;
    err_done = 1'bx;
    @(negedge clk);
    idle0 = m_busy | m_done | m_ce_src | m_ce_dst;
    err0  = m_err;
    rst = 1'b0;
    drive(1'b1, r0, c0, st);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin n_done++; cyc_done = cyc; err_done = m_err; end
      if (m_busy === 1'b1) begin
        n_busy++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (m_ce_src === 1'b1) rd_q.push_back(int'(m_asrc));
      if (m_ce_dst === 1'b1) begin wa_q.push_back(int'(m_adst)); wd_q.push_back(int'(m_wd)); end
      if (rst_at > 0 && cyc > rst_at && (m_busy | m_done | m_ce_src | m_ce_dst) !== 1'b0)
        n_after++;
      rst = (rst_at > 0 && cyc >= rst_at);
      drive((cyc < hold) || (cyc == pulse_at), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    s = 1 << st;
    n = dw * dh;
    fit = (r0 + (dh - 1) * s <= sh - 1) && (c0 + (dw - 1) * s <= sw - 1);
    check({tag, "/idle_at_start"}, 32'(idle0), 0);
    if (rst_at > 0) begin
      check({tag, "/done_after_abort"}, n_done, 0);
      check({tag, "/activity_after_rst"}, n_after, 0);
    end else begin
      check({tag, "/done_pulses"}, n_done, 1);
      check({tag, "/done_cycle"}, cyc_done, fit ? n + 2 : 1);
      check({tag, "/err"}, 32'(err_done), fit ? 0 : 1);
      check({tag, "/busy_cycles"}, n_busy, fit ? n + 1 : 0);
      check({tag, "/busy_first"}, busy_first, fit ? 1 : -1);
      check({tag, "/busy_last"}, busy_last, fit ? n + 1 : -1);
      check({tag, "/reads"}, rd_q.size(), fit ? n : 0);
      check({tag, "/writes"}, wa_q.size(), fit ? n : 0);
      bad_rd = 0; bad_wa = 0; bad_wd = 0;
      if (fit) begin
        for (int k = 0; k < n && k < rd_q.size() && k < wa_q.size(); k++) begin
          i = k / dw;
          j = k % dw;
          a = (r0 + i * s) * sw + c0 + j * s;
          if (rd_q[k] != a) bad_rd++;
          if (wa_q[k] != k) bad_wa++;
          if (wd_q[k] != int'(src_val(a))) bad_wd++;
        end
      end
      check({tag, "/bad_read_addrs"}, bad_rd, 0);
      check({tag, "/bad_write_addrs"}, bad_wa, 0);
      check({tag, "/bad_write_data"}, bad_wd, 0);
    end
  endtask

  function automatic int q_at(input int idx);
    return (idx >= 0 && idx < rd_q.size()) ? rd_q[idx] : -1;
  endfunction

  localparam int NA = 32 * 32;

  initial begin
    int r, c;
    ifa.start = 1'b0; ifa.crop_row = '0; ifa.crop_col = '0; ifa.step = '0;
    ifb.start = 1'b0; ifb.crop_row = '0; ifb.crop_col = '0; ifb.step = '0;
    set_sel(0);
    repeat (3) @(negedge clk);
    check("reset/busy", 32'(ifa.busy), 0);
    check("reset/done", 32'(ifa.done), 0);
    check("reset/err", 32'(ifa.err), 0);
    check("reset/ce_src", 32'(ifa.ce_src), 0);
    check("reset/ce_dst", 32'(ifa.ce_dst), 0);
    check("reset/addr_src", 32'(ifa.addr_src), 0);
    check("reset/addr_dst", 32'(ifa.addr_dst), 0);
    check("reset/b_busy", 32'(ifb.busy), 0);

    run("nominal", 26, 122, 0, 1, 0, 0, NA + 6);
    check("nominal/first_addr", q_at(0), 6778);
    check("nominal/last_addr", q_at(NA - 1), 14745);

    run("decim", 0, 0, 1, 1, 0, 0, NA + 6);
    check("decim/addr1", q_at(1), 2);
    check("decim/row1_addr", q_at(32), 512);
    check("decim/last_addr", q_at(NA - 1), 15934);

    run("corner_ok", 96, 224, 0, 1, 0, 0, NA + 6);
    check("corner_ok/last_addr", q_at(NA - 1), 32767);

    run("row_err", 97, 0, 0, 1, 0, 0, 8);
    run("s2_ok", 0, 124, 2, 1, 0, 0, NA + 6);
    check("s2_ok/err_sticky_before", 32'(err0), 1);
    run("s2_err", 4, 0, 2, 1, 0, 0, 8);
    run("s3_err", int'($urandom_range(0, 127)), int'($urandom_range(0, 255)), 3, 1, 0, 0, 8);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    r = int'($urandom_range(0, 96));
    c = int'($urandom_range(0, 224));
    run("handshake", r, c, 0, 3, 600, 0, NA + 6);
    check("handshake/err_cleared_by_rst", 32'(err0), 0);

    run("abort", 0, 0, 0, 1, 0, 500, 503);
    run("post_rst", 0, 0, 0, 1, 0, 0, NA + 6);

    for (int t = 0; t < 4; t++)
      run("rand_a", int'($urandom_range(0, 127)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 3)), 1, 0, 0, NA + 6);

    set_sel(1);
    run("param", 10, 20, 1, 1, 0, 0, 70);
    check("param/first_addr", q_at(0), 1020);
    check("param/addr7", q_at(7), 1034);
    check("param/row1_addr", q_at(8), 1220);
    for (int t = 0; t < 6; t++)
      run("rand_b", int'($urandom_range(0, 63)), int'($urandom_range(0, 127)),
          int'($urandom_range(0, 3)), 1, 0, 0, 70);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
